// File: rtl/button_press_decoder.sv
// rtl/button_press_decoder.sv - debounces a 4-button pressed vector into one clean event per press
// Multi-key presses raise press_multi instead of press_valid; every output is registered.
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pressed,
  input  logic       enable,
  output logic       press_valid,
  output logic [1:0] press_id,
  output logic       press_multi,
  output logic       holding
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sample;

  function automatic logic [1:0] encode(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sample      <= 4'b0000;
      press_valid <= 1'b0;
      press_id    <= 2'd0;
      press_multi <= 1'b0;
      holding     <= 1'b0;
    end else begin
      // Event outputs are pulses; they are only raised on the PRESS_DB->HELD edge.
      press_valid <= 1'b0;
      press_multi <= 1'b0;
      case (state)
        IDLE: begin
          holding <= 1'b0;
          if (enable && (pressed != 4'b0000)) begin
            sample <= pressed;
            cnt    <= '0;
            state  <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!enable || (pressed != sample)) begin
            state   <= IDLE;
            holding <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            holding <= 1'b1;
            if ($onehot(sample)) begin
              press_valid <= 1'b1;
              press_id    <= encode(sample);
            end else begin
              press_multi <= 1'b1;
            end
          end else begin
            cnt     <= cnt + 1'b1;
            holding <= 1'b0;
          end
        end
        HELD: begin
          holding <= 1'b1;
          if (pressed == 4'b0000) begin
            cnt   <= '0;
            state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          // Any nonzero sample is a release bounce: back to HELD without an event.
          if (pressed != 4'b0000) begin
            state   <= HELD;
            holding <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            holding <= 1'b0;
          end else begin
            cnt     <= cnt + 1'b1;
            holding <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          holding <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// tb/tb_button_press_decoder.sv - directed vector bench for button_press_decoder (DEBOUNCE_CYCLES=4)
module tb_button_press_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pressed = 4'b0000;
  logic       enable = 1'b0;
  logic       press_valid;
  logic [1:0] press_id;
  logic       press_multi;
  logic       holding;

  int errors = 0;
  int checks = 0;

  button_press_decoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pressed     (pressed),
    .enable      (enable),
    .press_valid (press_valid),
    .press_id    (press_id),
    .press_multi (press_multi),
    .holding     (holding)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] p;
    logic       en;
    logic       v;
    logic [1:0] id;
    logic       m;
    logic       h;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [3:0] p, input logic en,
                     input logic v, input logic [1:0] id, input logic m, input logic h);
    vec_t r;
    r.n = n; r.p = p; r.en = en; r.v = v; r.id = id; r.m = m; r.h = h;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] id,
                            input logic m, input logic h);
    chk({tag, ".press_valid"}, {1'b0, press_valid}, {1'b0, v});
    chk({tag, ".press_id"}, press_id, id);
    chk({tag, ".press_multi"}, {1'b0, press_multi}, {1'b0, m});
    chk({tag, ".holding"}, {1'b0, holding}, {1'b0, h});
  endtask

  // Drive for n cycles, expecting the same outputs after each edge.
  task automatic run(input string tag, input int n, input logic [3:0] p, input logic en,
                     input logic v, input logic [1:0] id, input logic m, input logic h);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pressed = p;
      enable  = en;
      @(posedge clk);
      #1;
      expect_out($sformatf("%s[%0d]", tag, i), v, id, m, h);
    end
  endtask

  initial begin
    // Single press of button 2, then release.
    add(4, 4'b0100, 1, 0, 0, 0, 0);
    add(1, 4'b0100, 1, 1, 2, 0, 1);
    add(5, 4'b0100, 1, 0, 2, 0, 1);
    add(4, 4'b0000, 1, 0, 2, 0, 1);
    add(2, 4'b0000, 1, 0, 2, 0, 0);
    // Press bounce, then a clean press of button 0.
    add(2, 4'b0001, 1, 0, 2, 0, 0);
    add(1, 4'b0000, 1, 0, 2, 0, 0);
    add(4, 4'b0001, 1, 0, 2, 0, 0);
    add(1, 4'b0001, 1, 1, 0, 0, 1);
    add(2, 4'b0001, 1, 0, 0, 0, 1);
    add(4, 4'b0000, 1, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 0, 0, 0, 0);
    // Two buttons at once.
    add(4, 4'b0011, 1, 0, 0, 0, 0);
    add(1, 4'b0011, 1, 0, 0, 1, 1);
    add(3, 4'b0011, 1, 0, 0, 0, 1);
    add(4, 4'b0000, 1, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++)
      run($sformatf("vec%0d", k), vecs[k].n, vecs[k].p, vecs[k].en,
          vecs[k].v, vecs[k].id, vecs[k].m, vecs[k].h);

    // Release bounce while held must not produce a second event.
    run("t4_press", 4, 4'b1000, 1, 0, 0, 0, 0);
    run("t4_fire", 1, 4'b1000, 1, 1, 3, 0, 1);
    run("t4_bounce0", 2, 4'b0000, 1, 0, 3, 0, 1);
    run("t4_bounce1", 3, 4'b1000, 1, 0, 3, 0, 1);
    run("t4_rel", 4, 4'b0000, 1, 0, 3, 0, 1);
    run("t4_idle", 2, 4'b0000, 1, 0, 3, 0, 0);
    run("t4_repress", 4, 4'b1000, 1, 0, 3, 0, 0);
    run("t4_refire", 1, 4'b1000, 1, 1, 3, 0, 1);
    run("t4_rel2", 4, 4'b0000, 1, 0, 3, 0, 1);
    run("t4_idle2", 1, 4'b0000, 1, 0, 3, 0, 0);

    // Enable low blocks presses; dropping enable mid-debounce aborts.
    run("t5_disabled", 8, 4'b0010, 0, 0, 3, 0, 0);
    run("t5_db", 3, 4'b0010, 1, 0, 3, 0, 0);
    run("t5_abort", 6, 4'b0010, 0, 0, 3, 0, 0);
    run("t5_clear", 2, 4'b0000, 0, 0, 3, 0, 0);

    // Reset while held: key still down at reset release counts as a new press.
    run("t6_press", 4, 4'b1000, 1, 0, 3, 0, 0);
    run("t6_fire", 1, 4'b1000, 1, 1, 3, 0, 1);
    run("t6_held", 2, 4'b1000, 1, 0, 3, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("t6_rst_async", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out($sformatf("t6_rst[%0d]", i), 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("t6_first_sample", 0, 0, 0, 0);
    run("t6_db", 3, 4'b1000, 1, 0, 0, 0, 0);
    run("t6_fire2", 1, 4'b1000, 1, 1, 3, 0, 1);
    run("t6_held2", 2, 4'b1000, 1, 0, 3, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
